// File: rtl/udma_uart_cfg_pkg.sv
// udma_uart_cfg_pkg
//   Shared definitions for the uDMA UART configuration sequencer: UART
//   register word addresses, the channel enable value, the sequencer state
//   encoding and the per-step register table entry.
package udma_uart_cfg_pkg;

  localparam logic [4:0]  REG_RX_SADDR = 5'h00;
  localparam logic [4:0]  REG_RX_SIZE  = 5'h01;
  localparam logic [4:0]  REG_RX_CFG   = 5'h02;
  localparam logic [4:0]  REG_TX_SADDR = 5'h04;
  localparam logic [4:0]  REG_TX_SIZE  = 5'h05;
  localparam logic [4:0]  REG_TX_CFG   = 5'h06;
  localparam logic [4:0]  REG_SETUP    = 5'h09;

  localparam logic [31:0] CFG_EN       = 32'h0000_0010;
  localparam logic [2:0]  LAST_IDX     = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        readback;
  } cfg_entry_t;

endpackage

// File: rtl/udma_uart_cfg_tbl.sv
// udma_uart_cfg_tbl
//   Combinational table that turns a sequence index (0..6) and the latched
//   operands into the register address, write data and readback flag for
//   that step. Addresses and sizes are zero-extended to 32 bits.
// Ports
//   idx       in   3    step index
//   setup     in   32   SETUP register value
//   rx_saddr  in   L2_AWIDTH_NOAL  RX start address
//   rx_size   in   TRANS_SIZE      RX byte count
//   tx_saddr  in   L2_AWIDTH_NOAL  TX start address
//   tx_size   in   TRANS_SIZE      TX byte count
//   entry     out  cfg_entry_t     register access for this step
module udma_uart_cfg_tbl
  import udma_uart_cfg_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20
) (
  input  logic [2:0]                idx,
  input  logic [31:0]               setup,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_saddr,
  input  logic [TRANS_SIZE-1:0]     rx_size,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_saddr,
  input  logic [TRANS_SIZE-1:0]     tx_size,
  output cfg_entry_t                entry
);

  always_comb begin
    entry = '0;
    case (idx)
      3'd0:    entry = '{REG_SETUP,    setup,          1'b1};
      3'd1:    entry = '{REG_RX_SADDR, 32'(rx_saddr),  1'b1};
      3'd2:    entry = '{REG_RX_SIZE,  32'(rx_size),   1'b1};
      3'd3:    entry = '{REG_RX_CFG,   CFG_EN,         1'b0};
      3'd4:    entry = '{REG_TX_SADDR, 32'(tx_saddr),  1'b1};
      3'd5:    entry = '{REG_TX_SIZE,  32'(tx_size),   1'b1};
      3'd6:    entry = '{REG_TX_CFG,   CFG_EN,         1'b0};
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/udma_uart_cfg_seq.sv
// udma_uart_cfg_seq
//   Masters the uDMA UART cfg_* register port. A start_i pulse in IDLE
//   latches the operands and writes SETUP, RX_SADDR, RX_SIZE, RX_CFG,
//   TX_SADDR, TX_SIZE, TX_CFG in that order, then pulses done_o. A request
//   left unaccepted for TIMEOUT cycles aborts the run with sticky err_o.
//   Optional build macro UDMA_UART_CFG_READBACK_EN: every SETUP/SADDR/SIZE
//   write is followed by a read of the same address; a data mismatch aborts
//   with err_o.
// Ports
//   sys_clk_i, rstn_i               clock, synchronous active-low reset
//   start_i                         begin sequence (IDLE only)
//   setup_i, rx_/tx_startaddr_i,
//   rx_/tx_size_i                   operands, latched at start
//   busy_o, done_o, err_o           status
//   cfg_addr_o, cfg_data_o,
//   cfg_rwn_o, cfg_valid_o          register request
//   cfg_ready_i, cfg_data_i         accept / read data
//
// state | meaning
// IDLE  | waiting for start_i, cfg port quiet
// XFER  | request idx_q (write, or readback when rd_q) on the cfg port
// DONE  | one-cycle done_o pulse
// ERR   | one-cycle abort after timeout or readback mismatch
module udma_uart_cfg_seq
  import udma_uart_cfg_pkg::*;
#(
  parameter int L2_AWIDTH_NOAL = 19,
  parameter int TRANS_SIZE     = 20,
  parameter int TIMEOUT        = 255
) (
  input  logic                      sys_clk_i,
  input  logic                      rstn_i,
  input  logic                      start_i,
  input  logic [31:0]               setup_i,
  input  logic [L2_AWIDTH_NOAL-1:0] rx_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     rx_size_i,
  input  logic [L2_AWIDTH_NOAL-1:0] tx_startaddr_i,
  input  logic [TRANS_SIZE-1:0]     tx_size_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  output logic                      cfg_rwn_o,
  output logic                      cfg_valid_o,
  input  logic                      cfg_ready_i,
  input  logic [31:0]               cfg_data_i
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  // Down-counter: loaded with TIMEOUT-1 per request, expiry when it sits at 0
  // with ready still low, i.e. after exactly TIMEOUT waiting cycles.
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);

  seq_state_t state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic          rd_q, rd_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;

  logic [31:0]               setup_q;
  logic [L2_AWIDTH_NOAL-1:0] rx_saddr_q, tx_saddr_q;
  logic [TRANS_SIZE-1:0]     rx_size_q, tx_size_q;

  cfg_entry_t entry;

  udma_uart_cfg_tbl #(
    .L2_AWIDTH_NOAL (L2_AWIDTH_NOAL),
    .TRANS_SIZE     (TRANS_SIZE)
  ) u_tbl (
    .idx      (idx_q),
    .setup    (setup_q),
    .rx_saddr (rx_saddr_q),
    .rx_size  (rx_size_q),
    .tx_saddr (tx_saddr_q),
    .tx_size  (tx_size_q),
    .entry    (entry)
  );

`ifndef UDMA_UART_CFG_READBACK_EN
  logic unused_rb;
  assign unused_rb = ^{cfg_data_i, entry.readback};
`endif

  always_ff @(posedge sys_clk_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      rd_q       <= 1'b0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      setup_q    <= '0;
      rx_saddr_q <= '0;
      rx_size_q  <= '0;
      tx_saddr_q <= '0;
      tx_size_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rd_q    <= rd_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      if (state_q == IDLE && start_i) begin
        setup_q    <= setup_i;
        rx_saddr_q <= rx_startaddr_i;
        rx_size_q  <= rx_size_i;
        tx_saddr_q <= tx_startaddr_i;
        tx_size_q  <= tx_size_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    cfg_valid_o = 1'b0;
    cfg_addr_o  = '0;
    cfg_data_o  = '0;
    cfg_rwn_o   = 1'b1;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = XFER;
          idx_d   = '0;
          rd_d    = 1'b0;
          tmo_d   = TMO_LOAD;
          err_d   = 1'b0;
        end
      end
      XFER: begin
        busy_o      = 1'b1;
        cfg_valid_o = 1'b1;
        cfg_addr_o  = entry.addr;
        cfg_data_o  = entry.data;
        cfg_rwn_o   = rd_q;
        if (cfg_ready_i) begin
          tmo_d = TMO_LOAD;
`ifdef UDMA_UART_CFG_READBACK_EN
          if (rd_q && (cfg_data_i != entry.data)) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (!rd_q && entry.readback) begin
            rd_d = 1'b1;
          end else
`endif
          begin
            rd_d = 1'b0;
            if (idx_q == LAST_IDX) state_d = DONE;
            else                   idx_d   = idx_q + 3'd1;
          end
        end else if (tmo_q == '0) begin
          state_d = ERR;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_o = err_q;

endmodule

// File: tb/tb_udma_uart_cfg_seq.sv
module tb_udma_uart_cfg_seq;

  localparam int AW = 19;
  localparam int SW = 20;
  localparam int TB_TIMEOUT = 4;
`ifdef UDMA_UART_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn_i = 1'b0;
  logic          start_i = 1'b0;
  logic [31:0]   setup_i = '0;
  logic [AW-1:0] rx_startaddr_i = '0, tx_startaddr_i = '0;
  logic [SW-1:0] rx_size_i = '0, tx_size_i = '0;
  logic          busy_o, done_o, err_o, cfg_rwn_o, cfg_valid_o;
  logic [4:0]    cfg_addr_o;
  logic [31:0]   cfg_data_o;
  logic          cfg_ready_i = 1'b0;
  logic [31:0]   cfg_data_i = '0;

  always #5 clk = ~clk;

  udma_uart_cfg_seq #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(SW), .TIMEOUT(TB_TIMEOUT)) dut (
    .sys_clk_i(clk), .rstn_i(rstn_i), .start_i(start_i), .setup_i(setup_i),
    .rx_startaddr_i(rx_startaddr_i), .rx_size_i(rx_size_i),
    .tx_startaddr_i(tx_startaddr_i), .tx_size_i(tx_size_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o), .cfg_rwn_o(cfg_rwn_o),
    .cfg_valid_o(cfg_valid_o), .cfg_ready_i(cfg_ready_i), .cfg_data_i(cfg_data_i)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        rwn;
  } xfer_t;

  xfer_t q[$];
  int n_vec = 0;
  int n_mis = 0;
  int end_cyc, end_how, n_xfers;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_w(input logic [4:0] a, input logic [31:0] d, input bit rb);
    xfer_t t;
    t.a = a; t.d = d; t.rwn = 1'b0;
    q.push_back(t);
    if (RB && rb) begin
      t.rwn = 1'b1;
      q.push_back(t);
    end
  endfunction

  task automatic rand_inputs();
    setup_i        = $urandom();
    rx_startaddr_i = AW'($urandom());
    tx_startaddr_i = AW'($urandom());
    rx_size_i      = SW'($urandom());
    tx_size_i      = SW'($urandom());
  endtask

  task automatic chk_quiet(input string tag, input bit exp_err);
    chk({tag, "_valid"}, cfg_valid_o, 0);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_err"},   err_o, 32'(exp_err));
    chk({tag, "_rwn"},   cfg_rwn_o, 1);
  endtask

  // end_how: 1 = done, 2 = error, 3 = reset mid-run
  task automatic run_seq(input string tag, input bit fixed_setup, input int stall_idx,
                         input int stall_len, input int mid_start_cyc, input int rst_cyc,
                         input bit corrupt);
    int cyc, xn, stalled, end_kind, end_next;
    logic [31:0] rd_val;
    @(negedge clk);
    if (fixed_setup) begin
      rand_inputs();
      setup_i = 32'h01B10308;
    end else rand_inputs();
    q.delete();
    push_w(5'h09, setup_i, 1);
    push_w(5'h00, 32'(rx_startaddr_i), 1);
    push_w(5'h01, 32'(rx_size_i), 1);
    push_w(5'h02, 32'h10, 0);
    push_w(5'h04, 32'(tx_startaddr_i), 1);
    push_w(5'h05, 32'(tx_size_i), 1);
    push_w(5'h06, 32'h10, 0);
    n_xfers = q.size();
    start_i = 1'b1;
    cfg_ready_i = 1'b0;
    @(posedge clk);
    cyc = 1; xn = 0; stalled = 0; end_kind = 0; end_next = 0; end_how = 0; end_cyc = 0;
    while (cyc < 80) begin
      @(negedge clk);
      start_i = 1'b0;
      if (end_kind == 0) begin
        chk({tag, "_valid"}, cfg_valid_o, 1);
        chk({tag, "_busy"},  busy_o, 1);
        chk({tag, "_done"},  done_o, 0);
        chk({tag, "_err"},   err_o, 0);
        chk({tag, "_addr"},  cfg_addr_o, 32'(q[0].a));
        chk({tag, "_data"},  cfg_data_o, q[0].d);
        chk({tag, "_rwn"},   cfg_rwn_o, 32'(q[0].rwn));
        if (cyc == rst_cyc) begin
          rstn_i = 1'b0;
          @(posedge clk);
          @(negedge clk);
          chk_quiet({tag, "_rst"}, 1'b0);
          chk({tag, "_rst_addr"}, cfg_addr_o, 0);
          chk({tag, "_rst_data"}, cfg_data_o, 0);
          rstn_i = 1'b1;
          end_how = 3;
          return;
        end
        if (xn == stall_idx && stalled < stall_len) begin
          cfg_ready_i = 1'b0;
          stalled++;
          if (stalled == TB_TIMEOUT) end_next = 2;
        end else begin
          cfg_ready_i = 1'b1;
          rd_val = q[0].d;
          if (q[0].rwn && corrupt && q[0].a == 5'h01) begin
            rd_val = rd_val ^ 32'h1;
            end_next = 2;
          end
          cfg_data_i = rd_val;
          void'(q.pop_front());
          xn++;
          if (end_next == 0 && q.size() == 0) end_next = 1;
        end
        if (cyc == mid_start_cyc) begin
          start_i = 1'b1;
          rand_inputs();
        end
        end_kind = end_next;
      end else begin
        chk({tag, "_end_done"},  done_o, 32'(end_kind == 1));
        chk({tag, "_end_err"},   err_o, 32'(end_kind == 2));
        chk({tag, "_end_valid"}, cfg_valid_o, 0);
        chk({tag, "_end_busy"},  busy_o, 0);
        end_how = end_kind;
        end_cyc = cyc;
        if (end_kind == 1) chk({tag, "_latency"}, 32'(cyc), 32'(n_xfers + 1 + stalled));
        break;
      end
      @(posedge clk);
      cyc++;
    end
    if (end_how == 0) chk({tag, "_budget"}, 0, 1);
    cfg_ready_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_quiet({tag, "_after"}, end_how == 2);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_quiet("reset", 1'b0);
    chk("reset_addr", cfg_addr_o, 0);
    chk("reset_data", cfg_data_o, 0);
    rstn_i = 1'b1;

    // T1: fixed setup, ready tied high
    run_seq("t1", 1, -1, 0, 0, 0, 0);
    chk("t1_done_cyc", 32'(end_cyc), RB ? 32'd13 : 32'd8);

    // T2: ready low 3 cycles on transfer 2
    run_seq("t2", 0, 2, 3, 0, 0, 0);
    chk("t2_done_cyc", 32'(end_cyc), RB ? 32'd16 : 32'd11);

    // stall of TIMEOUT-1 on the last transfer still completes
    run_seq("stall_last", 0, n_xfers - 1, TB_TIMEOUT - 1, 0, 0, 0);
    chk("stall_last_how", 32'(end_how), 1);

    // T3: ready stuck low -> error after exactly TIMEOUT waiting cycles
    run_seq("t3", 0, 0, 100, 0, 0, 0);
    chk("t3_how", 32'(end_how), 2);
    chk("t3_err_cyc", 32'(end_cyc), 32'(TB_TIMEOUT + 1));

    // timeout in the middle; the following run must clear err_o
    run_seq("tmo_mid", 0, 3, TB_TIMEOUT, 0, 0, 0);
    chk("tmo_mid_how", 32'(end_how), 2);
    run_seq("after_err", 0, -1, 0, 0, 0, 0);
    chk("after_err_how", 32'(end_how), 1);

    // T4: reset while transfer 3 is presented, then a full rerun
    run_seq("t4", 0, -1, 0, 0, 4, 0);
    chk("t4_how", 32'(end_how), 3);
    run_seq("t4_rerun", 0, -1, 0, 0, 0, 0);
    chk("t4_rerun_how", 32'(end_how), 1);

    // T5: start_i mid-run with new operands is ignored
    run_seq("t5", 0, -1, 0, 3, 0, 0);
    chk("t5_how", 32'(end_how), 1);

`ifdef UDMA_UART_CFG_READBACK_EN
    // T6: readback of RX_SIZE returns a flipped bit
    run_seq("t6", 0, -1, 0, 0, 0, 1);
    chk("t6_how", 32'(end_how), 2);
    chk("t6_err_cyc", 32'(end_cyc), 7);
`endif

    for (int i = 0; i < 6; i++) begin
      run_seq("rand", 0, int'($urandom_range(0, n_xfers - 1)),
              int'($urandom_range(0, TB_TIMEOUT)), 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
